pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with flush. O_READY is registered so
// there is no combinational path from I_READY back upstream.
//
// state | meaning
// EMPTY | no entry held, outputs show a bubble
// ONE   | MAIN holds the head entry
// TWO   | MAIN holds the head, SKID holds the next entry; upstream stalled
module pipe_skid_reg #(
    parameter int                CTRL_W      = 20,
    parameter int                DATA_W      = 128,
    parameter int                TAG_W       = 5,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_VALID,
    output logic              O_READY,
    input  logic [CTRL_W-1:0] I_CONTROL,
    input  logic [DATA_W-1:0] I_DATA,
    input  logic [TAG_W-1:0]  I_TAG,
    input  logic              I_FLUSH,
    output logic              O_VALID,
    input  logic              I_READY,
    output logic [CTRL_W-1:0] O_CONTROL,
    output logic [DATA_W-1:0] O_DATA,
    output logic [TAG_W-1:0]  O_TAG,
    output logic [1:0]        O_LEVEL
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ready_q;
    logic   accept, pop;
    logic   load_main_in, load_main_skid, load_skid;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [TAG_W-1:0]  main_tag, skid_tag;

    assign accept = I_VALID & ready_q;
    assign pop    = (state != EMPTY) & I_READY;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (I_FLUSH) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Ready is derived from the next state so it is a clean flop output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            main_tag  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= I_CONTROL;
                main_data <= I_DATA;
                main_tag  <= I_TAG;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                main_tag  <= skid_tag;
            end
            if (load_skid) begin
                skid_ctrl <= I_CONTROL;
                skid_data <= I_DATA;
                skid_tag  <= I_TAG;
            end
        end
    end

    // Bubbles carry a harmless control word and tag 0; data is left as-is.
    assign O_READY   = ready_q;
    assign O_VALID   = (state != EMPTY);
    assign O_LEVEL   = state;
    assign O_CONTROL = O_VALID ? main_ctrl : BUBBLE_CTRL;
    assign O_TAG     = O_VALID ? main_tag : '0;
    assign O_DATA    = main_data;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, a streaming run, and a long
// random run against a queue-based reference model.
module tb_pipe_skid_reg;
    localparam int CW = 20;
    localparam int DW = 128;
    localparam int TW = 5;
    localparam logic [CW-1:0] BUB = 20'hBBBBB;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          I_VALID = 1'b0;
    logic          I_FLUSH = 1'b0;
    logic          I_READY = 1'b0;
    logic [CW-1:0] I_CONTROL = '0;
    logic [DW-1:0] I_DATA = '0;
    logic [TW-1:0] I_TAG = '0;
    logic          O_READY, O_VALID;
    logic [CW-1:0] O_CONTROL;
    logic [DW-1:0] O_DATA;
    logic [TW-1:0] O_TAG;
    logic [1:0]    O_LEVEL;

    int n_checks = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .BUBBLE_CTRL(BUB)) dut (
        .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .O_READY(O_READY),
        .I_CONTROL(I_CONTROL), .I_DATA(I_DATA), .I_TAG(I_TAG), .I_FLUSH(I_FLUSH),
        .O_VALID(O_VALID), .I_READY(I_READY), .O_CONTROL(O_CONTROL),
        .O_DATA(O_DATA), .O_TAG(O_TAG), .O_LEVEL(O_LEVEL)
    );

    typedef struct {
        logic          rst, vld, flush, rdy;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          e_vld, e_rdy;
        logic [1:0]    e_lvl;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        logic [TW-1:0] e_tag;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ent_t;

    vec_t tbl[19];
    ent_t q[$];

    function automatic vec_t mk(logic rst, logic vld, logic flush, logic rdy,
                                logic [CW-1:0] ctrl, logic [DW-1:0] data, logic [TW-1:0] tag,
                                logic e_vld, logic e_rdy, logic [1:0] e_lvl,
                                logic [CW-1:0] e_ctrl, logic [DW-1:0] e_data, logic [TW-1:0] e_tag);
        vec_t v;
        v.rst = rst; v.vld = vld; v.flush = flush; v.rdy = rdy;
        v.ctrl = ctrl; v.data = data; v.tag = tag;
        v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_lvl = e_lvl;
        v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_tag = e_tag;
        return v;
    endfunction

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(string nm, logic e_vld, logic e_rdy, logic [1:0] e_lvl,
                           logic [CW-1:0] e_ctrl, logic [DW-1:0] e_data, logic [TW-1:0] e_tag);
        chk({nm, ".valid"}, DW'(O_VALID), DW'(e_vld));
        chk({nm, ".ready"}, DW'(O_READY), DW'(e_rdy));
        chk({nm, ".level"}, DW'(O_LEVEL), DW'(e_lvl));
        chk({nm, ".ctrl"},  DW'(O_CONTROL), DW'(e_ctrl));
        chk({nm, ".data"},  O_DATA, e_data);
        chk({nm, ".tag"},   DW'(O_TAG), DW'(e_tag));
    endtask

    initial begin
        logic          m_ready;
        logic [DW-1:0] m_last;
        logic          acc, pp;
        ent_t          e;

        // rst vld fl rdy ctrl data tag | vld rdy lvl ctrl data tag
        tbl[0]  = mk(1,0,0,0, 0,      0,     0,  0,0,0, BUB,    0,     0);
        tbl[1]  = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    0,     0);
        tbl[2]  = mk(0,1,0,1, 5,      'hA,   3,  1,1,1, 5,      'hA,   3);
        tbl[3]  = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    'hA,   0);
        tbl[4]  = mk(0,1,0,0, 'h11,   'h11,  1,  1,1,1, 'h11,   'h11,  1);
        tbl[5]  = mk(0,1,0,0, 'h22,   'h22,  2,  1,0,2, 'h11,   'h11,  1);
        tbl[6]  = mk(0,1,0,0, 'h33,   'h33,  9,  1,0,2, 'h11,   'h11,  1);
        tbl[7]  = mk(0,0,0,1, 0,      0,     0,  1,1,1, 'h22,   'h22,  2);
        tbl[8]  = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    'h22,  0);
        tbl[9]  = mk(0,1,0,0, 'h44,   'h44,  4,  1,1,1, 'h44,   'h44,  4);
        tbl[10] = mk(0,1,0,0, 'h55,   'h55,  5,  1,0,2, 'h44,   'h44,  4);
        tbl[11] = mk(0,1,1,1, 'h66,   'h66,  6,  0,1,0, BUB,    'h44,  0);
        tbl[12] = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    'h44,  0);
        tbl[13] = mk(0,1,0,0, 'h77,   'h77,  7,  1,1,1, 'h77,   'h77,  7);
        tbl[14] = mk(0,1,0,0, 'h88,   'h88,  8,  1,0,2, 'h77,   'h77,  7);
        tbl[15] = mk(1,1,1,1, 'h99,   'h99,  9,  0,0,0, BUB,    0,     0);
        tbl[16] = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    0,     0);
        tbl[17] = mk(0,0,0,1, 0,      0,     0,  0,1,0, BUB,    0,     0);
        tbl[18] = mk(0,1,0,1, 'h1,    'hF0,  1,  1,1,1, 'h1,    'hF0,  1);

        for (int i = 0; i < 19; i++) begin
            RESET = tbl[i].rst; I_VALID = tbl[i].vld; I_FLUSH = tbl[i].flush;
            I_READY = tbl[i].rdy; I_CONTROL = tbl[i].ctrl; I_DATA = tbl[i].data;
            I_TAG = tbl[i].tag;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_rdy, tbl[i].e_lvl,
                    tbl[i].e_ctrl, tbl[i].e_data, tbl[i].e_tag);
        end

        // Streaming: pipeline holds the 0xF0 entry; drain it, then push 1..8 back to back.
        I_VALID = 1'b0; I_READY = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            I_VALID = 1'b1; I_CONTROL = CW'(k + 'h100); I_DATA = DW'(k); I_TAG = TW'(k);
            tick();
            chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, CW'(k + 'h100), DW'(k), TW'(k));
        end
        I_VALID = 1'b0;
        tick();
        chk_all("stream_drain", 1'b0, 1'b1, 2'd0, BUB, DW'(8), '0);

        // Random run against a queue model; model ready follows the queue depth.
        m_ready = 1'b0;
        m_last  = '0;
        q.delete();
        RESET = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc > 0) RESET = ($urandom_range(0, 499) == 0);
            I_VALID   = ($urandom_range(0, 3) != 0);
            I_READY   = ($urandom_range(0, 2) != 0);
            I_FLUSH   = ($urandom_range(0, 59) == 0);
            I_CONTROL = CW'($urandom);
            I_DATA    = {$urandom, $urandom, $urandom, $urandom};
            I_TAG     = TW'($urandom);
            @(posedge CLK);
            if (RESET) begin
                q.delete();
                m_ready = 1'b0;
                m_last  = '0;
            end else if (I_FLUSH) begin
                q.delete();
                m_ready = 1'b1;
            end else begin
                acc = I_VALID && m_ready;
                pp  = (q.size() > 0) && I_READY;
                if (pp) void'(q.pop_front());
                if (acc) begin
                    e.c = I_CONTROL; e.d = I_DATA; e.t = I_TAG;
                    q.push_back(e);
                end
                m_ready = (q.size() < 2);
            end
            if (q.size() > 0) m_last = q[0].d;
            #1;
            if (q.size() > 0)
                chk_all($sformatf("rnd%0d", cyc), 1'b1, m_ready, 2'(q.size()), q[0].c, q[0].d, q[0].t);
            else
                chk_all($sformatf("rnd%0d", cyc), 1'b0, m_ready, 2'd0, BUB, m_last, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
